resta_serial: RTL and testbench
===============================

Name: resta_serial

Overview:
- Bit-serial subtractor. Computes d = a - b - bin over N clock cycles, one bit per cycle, LSB first.
- It is the inverse companion of the team's parallel ripple adder, and trades area for latency.
- It runs a start/done handshake and exports borrow, zero, negative and signed-overflow flags.
- It sits in the lab ALU datapath beside the parallel adder and is driven by the control FSM.

Parameters:
N, 8, operand and result width in bits (N >= 1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request pulse; sampled only in IDLE
a  input  N  minuend, captured on accepted start
b  input  N  subtrahend, captured on accepted start
bin  input  1  borrow-in, captured on accepted start
busy  output  1  high in RUN and DONE states
done  output  1  one-cycle pulse, results valid
d  output  N  difference a - b - bin (mod 2^N)
bout  output  1  unsigned borrow-out: 1 iff a < b + bin
zero  output  1  d == 0
neg  output  1  d[N-1]
ovf  output  1  two's-complement overflow: a[N-1] != b[N-1] and d[N-1] != a[N-1]

Behaviour:
- Reset: rst high at a clock edge puts the block in IDLE. It also clears the counter, the borrow flop, the shift registers, and every output (busy, done, d, bout, zero, neg, ovf) to 0.
- Reset mid-operation aborts the operation with no done pulse. Reset has priority over start.
- States:
  - IDLE: busy=0. On start=1, capture a, b and bin into internal shift registers and the borrow flop, clear the counter, go to RUN.
  - RUN: busy=1. Each edge processes bit i = LSB of the shift registers:
    - diff_i = a_i ^ b_i ^ br
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
    - diff_i shifts into the MSB of the result register; a and b shift right; counter increments.
    - After the N-th RUN edge, go to DONE.
  - DONE: lasts exactly one cycle. busy=1, done=1. Go to IDLE on the next edge.
- Output registration:
  - d, bout, zero, neg and ovf are registered on the transition into DONE. bout is the final borrow.
  - These outputs hold their values until the next DONE or reset. They do not change during a subsequent RUN.
- ovf uses the captured a[N-1] and b[N-1]; a copy is kept since the shift registers are consumed.
- Latency: start sampled at edge k. done is high during the cycle following edge k+N. Throughput is one operation per N+2 cycles.
- start in RUN or DONE is ignored. Operands changing after capture have no effect.
- N=1: a single RUN cycle, same rules.
- Wrap-around: results are modulo 2^N. Borrow beyond the MSB appears only on bout.

Test Plan:
- N=8. a=0x05, b=0x03, bin=0, start pulse -> busy high 9 cycles; done single pulse 8 cycles after the first RUN cycle; d=0x02, bout=0, zero=0, neg=0, ovf=0.
- a=0x03, b=0x05, bin=0 -> d=0xFE, bout=1, neg=1, zero=0, ovf=0.
- a=0x80, b=0x01, bin=0 -> d=0x7F, bout=0, neg=0, ovf=1. Also a=0x7F, b=0xFF -> d=0x80, bout=1, ovf=1.
- a=0x10, b=0x0F, bin=1 -> d=0x00, zero=1, bout=0. Results stay stable for 5 idle cycles afterward.
- Start a=0x20, b=0x01; during RUN pulse start with a=0xFF, b=0xFF -> second request ignored; d=0x1F, exactly one done pulse.
- Start a=0x44, b=0x11; assert rst at RUN cycle 4 -> next cycle all outputs 0, busy=0, no done. Then start a=0x00, b=0x00, bin=1 -> d=0xFF, bout=1, neg=1, ovf=0.

Source files
------------

// File: rtl/resta_serial.sv
// resta_serial: bit-serial subtractor, d = a - b - bin, one bit per cycle, LSB first.
// Start/done handshake; exports borrow, zero, negative and signed-overflow flags.
module resta_serial #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         zero,
    output logic         neg,
    output logic         ovf
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [N-1:0]    a_q, b_q, res_q;
    logic [CW-1:0]   cnt_q;
    logic            br_q;
    logic            amsb_q, bmsb_q;   // operand sign bits; the shift registers get consumed
    logic            busy_q, done_q, bout_q, zero_q, neg_q, ovf_q;
    logic [N-1:0]    d_q;

    logic            a_i, b_i, diff;
    logic            br_d, last;
    logic [N-1:0]    a_d, b_d, res_d;

    // One full-subtractor step on the current LSBs; difference enters the result MSB
    always_comb begin
        a_i        = a_q[0];
        b_i        = b_q[0];
        diff       = a_i ^ b_i ^ br_q;
        br_d       = (~a_i & b_i) | (~(a_i ^ b_i) & br_q);
        a_d        = a_q >> 1;
        b_d        = b_q >> 1;
        res_d      = res_q >> 1;
        res_d[N-1] = diff;
        last       = (cnt_q == CW'(N - 1));
    end

    // Control FSM with registered handshake and result flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        amsb_q  <= a[N-1];
                        bmsb_q  <= b[N-1];
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    br_q  <= br_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        d_q     <= res_d;
                        bout_q  <= br_d;
                        zero_q  <= (res_d == '0);
                        neg_q   <= res_d[N-1];
                        ovf_q   <= (amsb_q != bmsb_q) && (res_d[N-1] != amsb_q);
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;
    assign zero = zero_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_resta_serial.sv
// Directed bench for resta_serial: expected results queued at issue, checked by a monitor on done.
module tb_resta_serial;

    localparam int N = 8;

    typedef struct packed {
        logic [N-1:0] d;
        logic         bout;
        logic         zero;
        logic         neg;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, start, bin;
    logic [N-1:0] a, b;
    logic         busy, done, bout, zero, neg, ovf;
    logic [N-1:0] d;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    resta_serial #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .d(d), .bout(bout),
        .zero(zero), .neg(neg), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse consumes one expected result
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("d",    int'(d),    int'(e.d));
                check("bout", int'(bout), int'(e.bout));
                check("zero", int'(zero), int'(e.zero));
                check("neg",  int'(neg),  int'(e.neg));
                check("ovf",  int'(ovf),  int'(e.ovf));
            end
        end
    end

    // Issue one operation, optionally with a spurious start during RUN,
    // and check busy length, done latency and done count.
    task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bi,
                          input exp_t e, input bit inject);
        int bcnt, dcnt, dat;
        bit seen;
        @(posedge clk); #1;
        a = av; b = bv; bin = bi; start = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;       // start sampled at this edge
        start = 1'b0;
        a = ~av; b = ~bv; bin = ~bi;  // operands after capture must not matter
        bcnt = 0; dcnt = 0; dat = 0; seen = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (inject && i == 3) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF;
            end else if (inject && i == 4) begin
                start = 1'b0;
            end
            if (busy) begin bcnt++; seen = 1; end
            if (done) begin dcnt++; if (dat == 0) dat = i; end
            if (seen && !busy && i > 12) break;
        end
        start = 1'b0;
        check("busy_cycles", bcnt, N + 1);
        check("done_latency", dat, N + 1);
        check("done_count", dcnt, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_d", int'(d), 0);
        check("rst_flags", int'({bout, zero, neg, ovf}), 0);

        run_op(8'h05, 8'h03, 1'b0, '{d:8'h02, bout:0, zero:0, neg:0, ovf:0}, 0);
        run_op(8'h03, 8'h05, 1'b0, '{d:8'hFE, bout:1, zero:0, neg:1, ovf:0}, 0);
        run_op(8'h80, 8'h01, 1'b0, '{d:8'h7F, bout:0, zero:0, neg:0, ovf:1}, 0);
        run_op(8'h7F, 8'hFF, 1'b0, '{d:8'h80, bout:1, zero:0, neg:1, ovf:1}, 0);
        run_op(8'h10, 8'h0F, 1'b1, '{d:8'h00, bout:0, zero:1, neg:0, ovf:0}, 0);

        // Results hold while idle
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_d", int'(d), 0);
            check("hold_zero", int'(zero), 1);
            check("hold_busy", int'(busy), 0);
        end

        run_op(8'h20, 8'h01, 1'b0, '{d:8'h1F, bout:0, zero:0, neg:0, ovf:0}, 1);

        // Abort mid-RUN: no done, everything cleared
        @(posedge clk); #1;
        a = 8'h44; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_d", int'(d), 0);
        check("abort_flags", int'({bout, zero, neg, ovf}), 0);
        repeat (N + 2) begin
            @(negedge clk);
            check("abort_quiet", int'({busy, done}), 0);
        end

        run_op(8'h00, 8'h00, 1'b1, '{d:8'hFF, bout:1, zero:0, neg:1, ovf:0}, 0);

        repeat (3) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
